// File: rtl/tiled_layer_video_memory_if.sv
// Command stream into the tiled video memory: 32-bit words on a valid/ready handshake.
interface tiled_layer_video_memory_if;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/tiled_layer_video_memory.sv
// Multi-layer tile/sprite video memory with a fixed 4-edge pixel pipeline and colour-key blending.
// Optional macro TILE_FLIP_EN widens map entries to 10 bits with hflip (bit 8) and vflip (bit 9).
module tiled_layer_video_memory #(
  parameter int unsigned SPRITE_SIZE = 8,
  parameter int unsigned NUM_SPRITES = 256,
  parameter int unsigned MAP_W_TILES = 32,
  parameter int unsigned MAP_H_TILES = 64,
  parameter int unsigned LAYERS      = 2,
  parameter int unsigned X_BITS      = 8,
  parameter int unsigned Y_BITS      = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  tiled_layer_video_memory_if.slave    cmd,
  input  logic                         frame_start,
  input  logic                         in_display_region,
  input  logic                         pix_req,
  input  logic [X_BITS-1:0]            display_x,
  input  logic [Y_BITS-1:0]            display_y,
  output logic                         pixel_valid,
  output logic [15:0]                  pixel_out
);
  localparam int unsigned FineBits = $clog2(SPRITE_SIZE);
  localparam int unsigned SprDepth = NUM_SPRITES * SPRITE_SIZE * SPRITE_SIZE;
  localparam int unsigned SprAw    = $clog2(SprDepth);
  localparam int unsigned MapDepth = MAP_W_TILES * MAP_H_TILES;
  localparam int unsigned MapAw    = $clog2(MapDepth);
  localparam int unsigned MapXBits = $clog2(MAP_W_TILES * SPRITE_SIZE);
  localparam int unsigned MapYBits = $clog2(MAP_H_TILES * SPRITE_SIZE);
`ifdef TILE_FLIP_EN
  localparam int unsigned MapDw    = 10;
`else
  localparam int unsigned MapDw    = 8;
`endif

  logic [1:0]  cmd_tgt;
  logic [13:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        accept;

  // RAM ports are owned by the pixel path whenever it may be using them.
  assign cmd.cmd_ready = !reset && !in_display_region && !pix_req;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign {cmd_tgt, cmd_addr, cmd_wdata} = cmd.cmd_data;

  logic [MapXBits-1:0] scroll_x_sh_q [LAYERS];
  logic [MapXBits-1:0] scroll_x_q    [LAYERS];
  logic [MapYBits-1:0] scroll_y_sh_q [LAYERS];
  logic [MapYBits-1:0] scroll_y_q    [LAYERS];
  logic [15:0]         key_sh_q, key_q;

  logic                v0_q, v1_q, v2_q;
  logic [MapXBits-1:0] sx [LAYERS];
  logic [MapYBits-1:0] sy [LAYERS];
  logic [MapAw-1:0]    map_addr_q [LAYERS];
  logic [FineBits-1:0] fx0_q [LAYERS], fy0_q [LAYERS];
  logic [FineBits-1:0] fx1_q [LAYERS], fy1_q [LAYERS];
  logic [FineBits-1:0] fx_eff [LAYERS], fy_eff [LAYERS];
  logic [MapDw-1:0]    map_mem [LAYERS][MapDepth];
  logic [MapDw-1:0]    map_q [LAYERS];
  logic [15:0]         spr_mem [LAYERS][SprDepth];
  logic [SprAw-1:0]    spr_addr [LAYERS];
  logic [15:0]         spr_q [LAYERS];
  logic [15:0]         pix_sel;

  // Stage 0: scrolled map coordinates, wrapping at the map's pixel size by truncation.
  always_comb begin
    for (int l = 0; l < LAYERS; l++) begin
      sx[l] = MapXBits'(display_x) + scroll_x_q[l];
      sy[l] = MapYBits'(display_y) + scroll_y_q[l];
    end
  end

  // Stage 1: sprite address from the map entry and the carried fine offsets.
  always_comb begin
    for (int l = 0; l < LAYERS; l++) begin
      fx_eff[l] = fx1_q[l];
      fy_eff[l] = fy1_q[l];
`ifdef TILE_FLIP_EN
      // SPRITE_SIZE is a power of two, so SIZE-1-f is just the bitwise complement.
      if (map_q[l][8]) fx_eff[l] = ~fx1_q[l];
      if (map_q[l][9]) fy_eff[l] = ~fy1_q[l];
`endif
      spr_addr[l] = SprAw'({map_q[l][7:0], fy_eff[l], fx_eff[l]});
    end
  end

  always_comb begin
    pix_sel = spr_q[0];
    if (LAYERS == 2 && spr_q[LAYERS-1] != key_q) pix_sel = spr_q[LAYERS-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LAYERS; l++) begin
        scroll_x_sh_q[l] <= '0;
        scroll_x_q[l]    <= '0;
        scroll_y_sh_q[l] <= '0;
        scroll_y_q[l]    <= '0;
        map_addr_q[l]    <= '0;
        fx0_q[l]         <= '0;
        fy0_q[l]         <= '0;
        fx1_q[l]         <= '0;
        fy1_q[l]         <= '0;
      end
      key_sh_q    <= 16'hF81F;
      key_q       <= 16'hF81F;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_out   <= 16'h0000;
    end else begin
      // Live registers take the shadow value from before any same-edge control write.
      if (frame_start) begin
        for (int l = 0; l < LAYERS; l++) begin
          scroll_x_q[l] <= scroll_x_sh_q[l];
          scroll_y_q[l] <= scroll_y_sh_q[l];
        end
        key_q <= key_sh_q;
      end
      if (accept && cmd_tgt == 2'b11) begin
        case (cmd_addr)
          14'd0: scroll_x_sh_q[0] <= cmd_wdata[MapXBits-1:0];
          14'd1: scroll_y_sh_q[0] <= cmd_wdata[MapYBits-1:0];
          14'd2: if (LAYERS == 2) scroll_x_sh_q[LAYERS-1] <= cmd_wdata[MapXBits-1:0];
          14'd3: if (LAYERS == 2) scroll_y_sh_q[LAYERS-1] <= cmd_wdata[MapYBits-1:0];
          14'd4: key_sh_q <= cmd_wdata;
          default: ;
        endcase
      end
      for (int l = 0; l < LAYERS; l++) begin
        map_addr_q[l] <= {sy[l][MapYBits-1:FineBits], sx[l][MapXBits-1:FineBits]};
        fx0_q[l]      <= sx[l][FineBits-1:0];
        fy0_q[l]      <= sy[l][FineBits-1:0];
        fx1_q[l]      <= fx0_q[l];
        fy1_q[l]      <= fy0_q[l];
      end
      v0_q        <= pix_req;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      pixel_valid <= v2_q;
      if (v2_q) pixel_out <= pix_sel;
    end
  end

  // Each layer gets its own sprite RAM copy; writes go to every copy.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LAYERS; l++) begin
      if (accept && cmd_tgt == 2'b00) spr_mem[l][cmd_addr[SprAw-1:0]] <= cmd_wdata;
      if (accept && cmd_tgt == 2'(l + 1)) map_mem[l][cmd_addr[MapAw-1:0]] <= cmd_wdata[MapDw-1:0];
      map_q[l] <= map_mem[l][map_addr_q[l]];
      spr_q[l] <= spr_mem[l][spr_addr[l]];
    end
  end
endmodule
